// File: rtl/usr_cmd_sequencer_if.sv
// Command channel into usr_cmd_sequencer: one mode/count/data command per
// valid/ready handshake.
interface usr_cmd_sequencer_if #(
   parameter int CNT_W = 4,
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_count,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_count,
      input  cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Queues mode/count/data commands and replays each onto the universal shift
// register's S/I for `count` cycles, then returns S to hold and pulses done.
module usr_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4,
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   clear,
   usr_cmd_sequencer_if.slave     cmd_if,
   output logic [2:0]             S,
   output logic [WIDTH-1:0]       I,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [1:0]             o_dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [2:0]       r_op_mem   [DEPTH];
   logic [CNT_W-1:0] r_cnt_mem  [DEPTH];
   logic [WIDTH-1:0] r_data_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_next;
   logic [2:0]       r_s;
   logic [2:0]       w_s_next;
   logic [WIDTH-1:0] r_i;
   logic [WIDTH-1:0] w_i_next;
   logic             r_done;
   logic             w_done_next;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [2:0]       w_head_op;
   logic [CNT_W-1:0] w_head_cnt;
   logic [WIDTH-1:0] w_head_data;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
   // and clear is low; cmd_ready is !full only, so a same-cycle pop never frees a slot.
   assign w_full           = (r_level == LW'(DEPTH));
   assign w_empty          = (r_level == '0);
   assign cmd_if.cmd_ready = !w_full;
   assign w_push           = cmd_if.cmd_valid && !w_full;

   assign w_head_op   = r_op_mem[r_rd_ptr];
   assign w_head_cnt  = r_cnt_mem[r_rd_ptr];
   assign w_head_data = r_data_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push && !clear) begin
         r_op_mem[r_wr_ptr]   <= cmd_if.cmd_op;
         r_cnt_mem[r_wr_ptr]  <= cmd_if.cmd_count;
         r_data_mem[r_wr_ptr] <= cmd_if.cmd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_s         <= 3'b000;
         r_i         <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
         r_s         <= w_s_next;
         r_i         <= w_i_next;
         r_done      <= w_done_next;
      end
   end

   // Outputs are computed for the next state so S/I/done are plain registers.
   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_s_next         = 3'b000;
      w_i_next         = r_i;
      w_done_next      = 1'b0;
      w_pop            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head_cnt != '0) begin
                  w_state_next     = ST_RUN;
                  w_remaining_next = w_head_cnt;
                  w_s_next         = w_head_op;
                  w_i_next         = w_head_data;
               end else begin
                  w_state_next = ST_DONE;
                  w_done_next  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            w_remaining_next = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
               w_state_next = ST_DONE;
               w_done_next  = 1'b1;
            end else begin
               w_s_next = r_s;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign S           = r_s;
   assign I           = r_i;
   assign done        = r_done;
   assign busy        = (r_state != ST_IDLE);
   assign fifo_level  = r_level;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for usr_cmd_sequencer, with a 4-bit universal shift register
// model driven from S/I to score the data each command sequence produces.
module tb_usr_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int WIDTH = 4;
   localparam int W     = 11;

   logic             clk = 1'b0;
   logic             clear;
   logic [2:0]       s;
   logic [WIDTH-1:0] i_bus;
   logic             busy;
   logic             done;
   logic [2:0]       fifo_level;
   logic [1:0]       dbg_state;

   int n_cmp  = 0;
   int n_err  = 0;
   int rd_idx = 0;

   usr_cmd_sequencer_if #(.CNT_W(CNT_W), .WIDTH(WIDTH)) cmd_if ();

   usr_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .clear       (clear),
      .cmd_if      (cmd_if),
      .S           (s),
      .I           (i_bus),
      .busy        (busy),
      .done        (done),
      .fifo_level  (fifo_level),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time exceeded, wanted completion");
      $fatal(1);
   end

   // downstream shift register: 001 shr, 010 shl, 011 load, 100 rotr, 101 rotl, else hold
   logic [3:0] sr_q = 4'b0000;
   always @(posedge clk) begin
      case (s)
         3'b001:  sr_q <= {1'b0, sr_q[3:1]};
         3'b010:  sr_q <= {sr_q[2:0], 1'b0};
         3'b011:  sr_q <= i_bus;
         3'b100:  sr_q <= {sr_q[0], sr_q[3:1]};
         3'b101:  sr_q <= {sr_q[2:0], sr_q[3]};
         default: sr_q <= sr_q;
      endcase
   end

   // scoreboard: each done pulse records {run op, run length, shift register value}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   logic [2:0]   run_op    = 3'b000;
   int           run_len   = 0;
   int           nz_cycles = 0;
   bit           seen_111  = 1'b0;

   always @(negedge clk) begin
      if (clear) begin
         run_len <= 0;
      end else begin
         if (s != 3'b000) begin
            nz_cycles <= nz_cycles + 1;
            if (run_len == 0) run_op <= s;
            run_len <= run_len + 1;
         end
         if (s == 3'b111) seen_111 <= 1'b1;
         if (done) begin
            obs_q.push_back({(run_len == 0) ? 3'b000 : run_op, run_len[3:0], sr_q});
            run_len <= 0;
         end
      end
   end

   function automatic logic [W-1:0] mk(input logic [2:0] op, input logic [3:0] len,
                                       input logic [3:0] sr);
      return {op, len, sr};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] data);
      int waited;
      waited = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_count = cnt;
      cmd_if.cmd_data  = data;
      while (!cmd_if.cmd_ready && waited < 100) begin
         step();
         waited++;
      end
      n_cmp++;
      if (waited >= 100) begin
         n_err++;
         $display("FAIL push_wait: cmd_ready=%0b after %0d cycles, wanted 1", cmd_if.cmd_ready, waited);
      end
      step();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((busy || fifo_level != 3'd0) && guard < 400) begin
         step();
         guard++;
      end
      n_cmp++;
      if (guard >= 400) begin
         n_err++;
         $display("FAIL %s_drain: busy=%0b level=%0d after %0d cycles, wanted idle/empty",
                  name, busy, fifo_level, guard);
      end
      while (exp_q.size() > 0) begin
         n_cmp++;
         if (rd_idx >= obs_q.size()) begin
            n_err++;
            $display("FAIL %s_window: no window observed, wanted op/len/sr=%b", name, exp_q[0]);
         end else if (obs_q[rd_idx] !== exp_q[0]) begin
            n_err++;
            $display("FAIL %s_window: got op/len/sr=%b, wanted %b", name, obs_q[rd_idx], exp_q[0]);
         end
         rd_idx++;
         void'(exp_q.pop_front());
      end
      n_cmp++;
      if (obs_q.size() != rd_idx) begin
         n_err++;
         $display("FAIL %s_windows: got %0d windows, wanted %0d", name, obs_q.size(), rd_idx);
         rd_idx = obs_q.size();
      end
   endtask

   task automatic test_reset();
      clear            = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'b011;
      cmd_if.cmd_count = 4'd5;
      cmd_if.cmd_data  = 4'hf;
      repeat (3) step();
      n_cmp++; if (s !== 3'b000) begin n_err++; $display("FAIL reset_s: got %b, wanted 000", s); end
      n_cmp++; if (i_bus !== 4'b0000) begin n_err++; $display("FAIL reset_i: got %b, wanted 0000", i_bus); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, wanted 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, wanted 0", done); end
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d, wanted 0", fifo_level); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, wanted 0", dbg_state); end
      clear            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, wanted 1", cmd_if.cmd_ready); end
      step();
      n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_accept: level got %0d, wanted 0", fifo_level); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy got %b, wanted 0", busy); end
   endtask

   task automatic test_single();
      logic [2:0] es [8];
      logic       ed [8];
      logic [3:0] ei [8];
      es = '{3'b011, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
      ed = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ei = '{4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      exp_q.push_back(mk(3'b011, 4'd1, 4'b1001));
      exp_q.push_back(mk(3'b100, 4'd3, 4'b0011));
      push(3'b011, 4'd1, 4'b1001);
      push(3'b100, 4'd3, 4'b0000);
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (s !== es[c] || done !== ed[c] || i_bus !== ei[c]) begin
            n_err++;
            $display("FAIL single_trace[%0d]: got S=%b done=%b I=%b, wanted S=%b done=%b I=%b",
                     c, s, done, i_bus, es[c], ed[c], ei[c]);
         end
         step();
      end
      drain("single");
   endtask

   task automatic test_fifo_full();
      int waited;
      exp_q.push_back(mk(3'b100, 4'd15, 4'b0110));
      exp_q.push_back(mk(3'b011, 4'd1,  4'b1010));
      exp_q.push_back(mk(3'b010, 4'd1,  4'b0100));
      exp_q.push_back(mk(3'b001, 4'd2,  4'b0001));
      exp_q.push_back(mk(3'b101, 4'd3,  4'b1000));
      exp_q.push_back(mk(3'b011, 4'd2,  4'b0101));
      push(3'b100, 4'd15, 4'b0000);
      step();
      push(3'b011, 4'd1, 4'b1010);
      push(3'b010, 4'd1, 4'b0000);
      push(3'b001, 4'd2, 4'b0000);
      n_cmp++;
      if (fifo_level !== 3'd3 || cmd_if.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL full_level3: got level=%0d ready=%b, wanted 3/1", fifo_level, cmd_if.cmd_ready);
      end
      push(3'b101, 4'd3, 4'b0000);
      n_cmp++;
      if (fifo_level !== 3'd4 || cmd_if.cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_level4: got level=%0d ready=%b, wanted 4/0", fifo_level, cmd_if.cmd_ready);
      end
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'b011;
      cmd_if.cmd_count = 4'd2;
      cmd_if.cmd_data  = 4'b0101;
      waited = 0;
      while (!cmd_if.cmd_ready && waited < 100) begin
         step();
         waited++;
      end
      n_cmp++;
      if (waited != 13 || fifo_level !== 3'd3) begin
         n_err++;
         $display("FAIL full_stall: got %0d stall cycles level=%0d, wanted 13/3", waited, fifo_level);
      end
      step();
      cmd_if.cmd_valid = 1'b0;
      n_cmp++;
      if (fifo_level !== 3'd4) begin
         n_err++;
         $display("FAIL full_accept: level got %0d, wanted 4", fifo_level);
      end
      drain("full");
   endtask

   task automatic test_count_zero();
      exp_q.push_back(mk(3'b000, 4'd0, 4'b0101));
      push(3'b111, 4'd0, 4'b1111);
      n_cmp++;
      if (done !== 1'b0 || fifo_level !== 3'd1) begin
         n_err++;
         $display("FAIL zero_queued: got done=%b level=%0d, wanted 0/1", done, fifo_level);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || s !== 3'b000 || fifo_level !== 3'd0 || dbg_state !== 2'd2) begin
         n_err++;
         $display("FAIL zero_done: got done=%b S=%b level=%0d state=%0d, wanted 1/000/0/2",
                  done, s, fifo_level, dbg_state);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_end: got done=%b busy=%b, wanted 0/0", done, busy);
      end
      drain("zero");
      n_cmp++;
      if (seen_111 !== 1'b0) begin
         n_err++;
         $display("FAIL zero_s111: S=111 observed=%b, wanted 0", seen_111);
      end
   endtask

   task automatic test_abort();
      int nz_snap;
      int win_snap;
      push(3'b001, 4'd8, 4'b0000);
      push(3'b011, 4'd1, 4'b1111);
      push(3'b100, 4'd1, 4'b0000);
      n_cmp++;
      if (s !== 3'b001 || fifo_level !== 3'd2) begin
         n_err++;
         $display("FAIL abort_run: got S=%b level=%0d, wanted 001/2", s, fifo_level);
      end
      clear = 1'b1;
      step();
      n_cmp++;
      if (s !== 3'b000 || done !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_clear: got S=%b done=%b level=%0d busy=%b, wanted 000/0/0/0",
                  s, done, fifo_level, busy);
      end
      clear    = 1'b0;
      nz_snap  = nz_cycles;
      win_snap = obs_q.size();
      repeat (12) step();
      n_cmp++;
      if (nz_cycles != nz_snap || obs_q.size() != win_snap) begin
         n_err++;
         $display("FAIL abort_quiet: got %0d active S cycles %0d done pulses, wanted 0/0",
                  nz_cycles - nz_snap, obs_q.size() - win_snap);
      end
      drain("abort");
   endtask

   task automatic test_boundary();
      exp_q.push_back(mk(3'b011, 4'd1,  4'b0110));
      exp_q.push_back(mk(3'b101, 4'd15, 4'b0011));
      exp_q.push_back(mk(3'b010, 4'd1,  4'b0110));
      exp_q.push_back(mk(3'b011, 4'd2,  4'b1001));
      push(3'b011, 4'd1, 4'b0110);
      push(3'b101, 4'd15, 4'b0000);
      push(3'b010, 4'd1, 4'b0000);
      step();
      n_cmp++;
      if (fifo_level !== 3'd2 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bound_pre: got level=%0d busy=%b, wanted 2/0", fifo_level, busy);
      end
      push(3'b011, 4'd2, 4'b1001);
      n_cmp++;
      if (fifo_level !== 3'd2 || s !== 3'b101) begin
         n_err++;
         $display("FAIL bound_pushpop: got level=%0d S=%b, wanted 2/101", fifo_level, s);
      end
      drain("bound");
   endtask

   initial begin
      clear            = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 3'b000;
      cmd_if.cmd_count = '0;
      cmd_if.cmd_data  = '0;
      test_reset();
      test_single();
      test_fifo_full();
      test_count_zero();
      test_abort();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
